// File: rtl/phy_rx.sv
// Serial-to-parallel receiver: comma-based byte alignment, then round-robin
// delivery of data bytes onto four output lanes.

module phy_rx_lane (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       vld_o
);

   logic [7:0] data_q;
   logic       vld_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= 8'h00;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= wr_i;
         if (wr_i) data_q <= data_i;
      end
   end

   assign data_o = data_q;
   assign vld_o  = vld_q;

endmodule

module phy_rx #(
   parameter logic [7:0] COMMA    = 8'hBC,
   parameter int         LOCK_CNT = 4
) (
   input  logic       clk32f,
   input  logic       reset,
   input  logic       in_serial,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic [3:0] valid_out,
   output logic       active
);

   localparam int NUM_LANES = 4;
   localparam int LOCK_N    = (LOCK_CNT < 1) ? 1 : LOCK_CNT;
   localparam int CW        = $clog2(LOCK_N + 1);
   localparam logic [CW-1:0] LOCK_V = CW'(LOCK_N);

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_ALIGN  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [7:0]    sr_q;
   logic [2:0]    bit_q, bit_d;
   logic [CW-1:0] comma_q, comma_d, comma_inc;
   logic [1:0]    lane_q, lane_d;
   logic          active_q, active_d;

   logic [7:0]    cand;
   logic          is_comma;
   logic          boundary;
   logic [NUM_LANES-1:0]       wr;
   logic [NUM_LANES-1:0][7:0]  lane_data;

   // The byte completing on this edge includes the bit being sampled now.
   assign cand      = {sr_q[6:0], in_serial};
   assign is_comma  = (cand == COMMA);
   assign boundary  = (bit_q == 3'd7);
   assign comma_inc = (comma_q == LOCK_V) ? comma_q : comma_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q + 3'd1;
      comma_d  = comma_q;
      lane_d   = lane_q;
      active_d = active_q;
      wr       = '0;
      case (state_q)
         S_HUNT: begin
            bit_d = 3'd0;
            if (is_comma) begin
               comma_d = CW'(1);
               if (LOCK_V <= CW'(1)) begin
                  state_d  = S_LOCKED;
                  active_d = 1'b1;
               end else begin
                  state_d = S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_d = comma_inc;
                  if (comma_inc >= LOCK_V) begin
                     state_d  = S_LOCKED;
                     active_d = 1'b1;
                  end
               end else begin
                  state_d = S_HUNT;
                  comma_d = '0;
               end
            end
         end
         S_LOCKED: begin
            if (boundary) begin
               if (is_comma) begin
                  lane_d = 2'd0;
               end else begin
                  wr[lane_q] = 1'b1;
                  lane_d     = lane_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = S_HUNT;
            comma_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk32f or posedge reset) begin
      if (reset) begin
         state_q  <= S_HUNT;
         sr_q     <= 8'h00;
         bit_q    <= 3'd0;
         comma_q  <= '0;
         lane_q   <= 2'd0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= cand;
         bit_q    <= bit_d;
         comma_q  <= comma_d;
         lane_q   <= lane_d;
         active_q <= active_d;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      phy_rx_lane u_lane (
         .clk_i  (clk32f),
         .rst_i  (reset),
         .wr_i   (wr[g]),
         .data_i (cand),
         .data_o (lane_data[g]),
         .vld_o  (valid_out[g])
      );
   end

   assign out0   = lane_data[0];
   assign out1   = lane_data[1];
   assign out2   = lane_data[2];
   assign out3   = lane_data[3];
   assign active = active_q;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: a byte table for lock/delivery/wrap behaviour,
// plus hand sequences for misalignment, false alignment and mid-byte reset.

module tb_phy_rx;

   logic       clk32f = 1'b0;
   logic       reset  = 1'b1;
   logic       in_serial = 1'b0;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] valid_out;
   logic       active;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] b;
      logic       act;
      logic [3:0] vld;
      logic [7:0] o0, o1, o2, o3;
   } vec_t;

   vec_t tbl [21];

   phy_rx dut (
      .clk32f    (clk32f),
      .reset     (reset),
      .in_serial (in_serial),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .valid_out (valid_out),
      .active    (active)
   );

   always #5 clk32f = ~clk32f;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic a, input logic [3:0] v,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
      chk({tag, ".active"}, 32'(active), 32'(a));
      chk({tag, ".valid"},  32'(valid_out), 32'(v));
      chk({tag, ".out0"},   32'(out0), 32'(e0));
      chk({tag, ".out1"},   32'(out1), 32'(e1));
      chk({tag, ".out2"},   32'(out2), 32'(e2));
      chk({tag, ".out3"},   32'(out3), 32'(e3));
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk32f);
      in_serial = b;
      @(posedge clk32f);
      #1;
   endtask

   // Mid-byte cycles must never carry a valid pulse.
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i != 0) chk("midbyte.valid", 32'(valid_out), 32'h0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk32f);
      reset = 1'b1;
      repeat (2) @(negedge clk32f);
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic [7:0] b, input logic a, input logic [3:0] v,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
      vec_t r;
      r.b = b; r.act = a; r.vld = v;
      r.o0 = e0; r.o1 = e1; r.o2 = e2; r.o3 = e3;
      return r;
   endfunction

   initial begin
      // lock, four lanes, comma re-aligning the pointer, then wrap
      tbl[0]  = mk(8'hBC, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      tbl[1]  = mk(8'hBC, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      tbl[2]  = mk(8'hBC, 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      tbl[3]  = mk(8'hBC, 1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      tbl[4]  = mk(8'h11, 1, 4'h1, 8'h11, 8'h00, 8'h00, 8'h00);
      tbl[5]  = mk(8'h22, 1, 4'h2, 8'h11, 8'h22, 8'h00, 8'h00);
      tbl[6]  = mk(8'h33, 1, 4'h4, 8'h11, 8'h22, 8'h33, 8'h00);
      tbl[7]  = mk(8'h44, 1, 4'h8, 8'h11, 8'h22, 8'h33, 8'h44);
      tbl[8]  = mk(8'h01, 1, 4'h1, 8'h01, 8'h22, 8'h33, 8'h44);
      tbl[9]  = mk(8'h02, 1, 4'h2, 8'h01, 8'h02, 8'h33, 8'h44);
      tbl[10] = mk(8'hBC, 1, 4'h0, 8'h01, 8'h02, 8'h33, 8'h44);
      tbl[11] = mk(8'h03, 1, 4'h1, 8'h03, 8'h02, 8'h33, 8'h44);
      tbl[12] = mk(8'hBC, 1, 4'h0, 8'h03, 8'h02, 8'h33, 8'h44);
      tbl[13] = mk(8'h10, 1, 4'h1, 8'h10, 8'h02, 8'h33, 8'h44);
      tbl[14] = mk(8'h11, 1, 4'h2, 8'h10, 8'h11, 8'h33, 8'h44);
      tbl[15] = mk(8'h12, 1, 4'h4, 8'h10, 8'h11, 8'h12, 8'h44);
      tbl[16] = mk(8'h13, 1, 4'h8, 8'h10, 8'h11, 8'h12, 8'h13);
      tbl[17] = mk(8'h14, 1, 4'h1, 8'h14, 8'h11, 8'h12, 8'h13);
      tbl[18] = mk(8'h15, 1, 4'h2, 8'h14, 8'h15, 8'h12, 8'h13);
      tbl[19] = mk(8'h16, 1, 4'h4, 8'h14, 8'h15, 8'h16, 8'h13);
      tbl[20] = mk(8'h17, 1, 4'h8, 8'h14, 8'h15, 8'h16, 8'h17);

      repeat (2) @(negedge clk32f);
      chk_all("reset", 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         send_byte(tbl[i].b);
         chk_all($sformatf("tbl[%0d]", i), tbl[i].act, tbl[i].vld,
                 tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].o3);
      end
      send_bit(1'b0);
      chk("tbl.pulse_end", 32'(valid_out), 32'h0);

      // alignment at a 3-bit offset
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
      chk("off3.active", 32'(active), 32'h1);
      send_byte(8'hA5);
      chk_all("off3", 1, 4'h1, 8'hA5, 8'h00, 8'h00, 8'h00);

      // broken alignment returns to hunt
      do_reset();
      send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
      chk_all("realign.break", 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      chk("realign.bc3.active", 32'(active), 32'h0);
      send_byte(8'hBC);
      chk("realign.bc4.active", 32'(active), 32'h1);
      send_byte(8'h5A);
      chk_all("realign", 1, 4'h1, 8'h5A, 8'h00, 8'h00, 8'h00);

      // asynchronous reset mid-byte while locked
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
      send_byte(8'h77);
      chk_all("pre_rst", 1, 4'h1, 8'h77, 8'h00, 8'h00, 8'h00);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      #2 reset = 1'b1;
      #1 chk_all("async_rst", 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk32f);
      reset = 1'b0;
      send_byte(8'hBC);
      send_byte(8'h55);
      chk_all("post_rst.nolock", 0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
      send_byte(8'h66);
      chk_all("post_rst.relock", 1, 4'h1, 8'h66, 8'h00, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/phy_rx.md
PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 SHALL have port clk32f, input, 1 bit: serial bit clock; all state is updated on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_serial, input, 1 bit: serial data stream, MSB first, one bit sampled per clk32f rising edge.
REQ-004 SHALL have ports out0, out1, out2, out3, output, 8 bits each: recovered data bytes for lanes 0..3, registered.
REQ-005 SHALL have port valid_out, output, 4 bits: bit k flags a new byte on outk, registered.
REQ-006 SHALL have port active, output, 1 bit: high while byte alignment is locked, registered.
REQ-007 SHALL define parameter COMMA, default 8'hBC: the alignment/idle symbol.
REQ-008 SHALL define parameter LOCK_CNT, default 4: number of consecutive aligned COMMA bytes required for lock.

Function
REQ-009 SHALL shift in_serial into an 8-bit register every cycle; candidate byte = {sr[6:0], in_serial}.
REQ-010 SHALL implement FSM states HUNT, ALIGN and LOCKED; reset state is HUNT.
REQ-011 HUNT: candidate byte checked every cycle; on candidate == COMMA -> ALIGN, bit counter cleared to 0, comma count = 1.
REQ-012 Bit counter: 3 bits, increments every cycle outside HUNT, wraps 7 -> 0; a byte boundary is the cycle where the counter == 7.
REQ-013 ALIGN, at each byte boundary: candidate == COMMA -> comma count + 1; when the count reaches LOCK_CNT -> LOCKED, with active high from the next cycle.
REQ-014 ALIGN, at a byte boundary with candidate != COMMA -> HUNT, comma count = 0, nothing delivered.
REQ-015 ALIGN and HUNT: valid_out SHALL stay 4'b0000 and out0..out3 SHALL hold their values.
REQ-016 LOCKED, byte boundary with candidate == COMMA: idle symbol; no valid pulse; lane pointer reset to 0.
REQ-017 LOCKED, byte boundary with candidate != COMMA: candidate written to out[lane pointer]; valid_out[lane pointer] pulses high for exactly 1 cycle; lane pointer increments mod 4 (3 -> 0).
REQ-018 Latency: outk and valid_out[k] SHALL be visible immediately after the clock edge that samples the byte's last (LSB) bit.
REQ-019 LOCKED state SHALL persist until reset; non-comma data never drops lock.
REQ-020 At most one valid_out bit SHALL be high in any cycle; other lanes' outputs are unchanged on a write.
REQ-021 Comma count SHALL saturate at LOCK_CNT and never wrap.

Reset
REQ-022 Reset assertion SHALL asynchronously force: state HUNT, shift register 8'h00, bit counter 0, comma count 0, lane pointer 0, out0..out3 8'h00, valid_out 4'b0000, active 0.
REQ-023 Reset asserted mid-byte or mid-frame SHALL discard the partial byte; after deassertion the block re-hunts from the next sampled bit.
REQ-024 First sample SHALL be taken on the first clk32f rising edge after reset deassertion.

Verification
REQ-025 Scenario 1: after reset, 4x 8'hBC then 8'h11, 8'h22, 8'h33, 8'h44 -> active rises after the 32nd bit; out0=11, out1=22, out2=33, out3=44, each with a 1-cycle valid pulse spaced 8 cycles apart.
REQ-026 Scenario 2: 3 garbage bits 3'b101 precede 4x BC then 8'hA5 -> alignment found at bit offset 3; out0=A5 with valid_out=4'b0001.
REQ-027 Scenario 3: BC, BC, 8'h00, BC, BC, BC, BC, 8'h5A -> return to HUNT at the 8'h00; active stays low until the 4th subsequent BC; out0=5A.
REQ-028 Scenario 4: locked; send 8'h01, 8'h02, BC, 8'h03 -> out0=01, out1=02, BC yields no valid, then out0=03 (pointer reset to 0).
REQ-029 Scenario 5: locked; assert reset after 4 bits of 8'hF0 -> all outputs 0 and active 0 immediately (asynchronous); full relock needed before the next valid.
REQ-030 Scenario 6: locked; send 8 non-comma bytes 8'h10..8'h17 -> lane pointer wraps; out0=14, out1=15, out2=16, out3=17 at the end; active stays 1 throughout.
